// File: rtl/reg_bank_pkg.sv
// Shared register-bank constants, the write-entry record and the one-hot
// destination decode used by both the write-back path and the bank decoder.
package reg_bank_pkg;

  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned NUM_REGS  = 16;
  localparam int unsigned DATA_W    = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] dest;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } wb_src_t;

  function automatic logic [NUM_REGS-1:0] onehot16(input logic [REG_IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_writeback_ctrl_wb_fifo.sv
// DEPTH-entry synchronous FIFO of (dest, data) write requests, with per-entry
// valid/dest taps so the owner can build a pending-write vector.
module wb_fifo
  import reg_bank_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [REG_IDX_W-1:0]              push_dest,
  input  logic [DATA_W-1:0]                 push_data,
  input  logic                              pop,
  output logic [REG_IDX_W-1:0]              head_dest,
  output logic [DATA_W-1:0]                 head_data,
  output logic                              full,
  output logic                              empty,
  output logic [PTR_W:0]                    count,
  output logic [DEPTH-1:0]                  ent_valid,
  output logic [DEPTH-1:0][REG_IDX_W-1:0]   ent_dest
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     cnt;
  logic [DEPTH-1:0]   vld;
  logic               do_push;
  logic               do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Push and pop only alias the same slot when empty or full, and each is
  // blocked in one of those cases, so the valid-flag updates never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr      <= wr_ptr + 1'b1;
        vld[wr_ptr] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        vld[rd_ptr] <= 1'b0;
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + 1'b1;
      end else if (!do_push && do_pop) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= '{dest: push_dest, data: push_data};
    end
  end

  always_comb begin
    ent_dest = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_dest[i] = mem[i].dest;
    end
  end

  assign head_dest = mem[rd_ptr].dest;
  assign head_data = mem[rd_ptr].data;
  assign count     = cnt;
  assign ent_valid = vld;

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Write-side sequencer for the register bank: arbitrates ALU and load writes,
// buffers them, issues one registered write per cycle and publishes busy bits.
module reg_writeback_ctrl
  import reg_bank_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [3:0]        alu_dest,
  input  logic [31:0]       alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [3:0]        ld_dest,
  input  logic [31:0]       ld_data,
  input  logic              drain_stall,
  output logic              wr_en,
  output logic [3:0]        wr_dest,
  output logic [31:0]       wr_data,
  output logic [15:0]       busy,
  output logic [PTR_W:0]    count
);

  wb_src_t                             sel_src;
  logic                                push;
  logic [REG_IDX_W-1:0]                push_dest;
  logic [DATA_W-1:0]                   push_data;
  logic                                pop;
  logic [REG_IDX_W-1:0]                head_dest;
  logic [DATA_W-1:0]                   head_data;
  logic                                full;
  logic                                empty;
  logic [DEPTH-1:0]                    ent_valid;
  logic [DEPTH-1:0][REG_IDX_W-1:0]     ent_dest;

  // Ready is derived from occupancy and ld_valid only, never from alu_valid.
  assign ld_ready  = !full;
  assign alu_ready = !full && !ld_valid;

  always_comb begin
    sel_src   = ld_valid ? SRC_LD : SRC_ALU;
    push      = 1'b0;
    push_dest = alu_dest;
    push_data = alu_data;
    unique case (sel_src)
      SRC_LD: begin
        push      = ld_valid && ld_ready;
        push_dest = ld_dest;
        push_data = ld_data;
      end
      SRC_ALU: begin
        push      = alu_valid && alu_ready;
      end
      default: ;
    endcase
  end

  assign pop = !empty && !drain_stall;

  wb_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_dest (push_dest),
    .push_data (push_data),
    .pop       (pop),
    .head_dest (head_dest),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ent_valid (ent_valid),
    .ent_dest  (ent_dest)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_dest <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= pop;
      if (pop) begin
        wr_dest <= head_dest;
        wr_data <= head_data;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) begin
        busy = busy | onehot16(ent_dest[i]);
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: directed vector table, then queue-model-checked
// alternating and random traffic.
module tb_reg_writeback_ctrl;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic              clk;
  logic              rst;
  logic              alu_valid;
  logic              alu_ready;
  logic [3:0]        alu_dest;
  logic [31:0]       alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [3:0]        ld_dest;
  logic [31:0]       ld_data;
  logic              drain_stall;
  logic              wr_en;
  logic [3:0]        wr_dest;
  logic [31:0]       wr_data;
  logic [15:0]       busy;
  logic [PTR_W:0]    count;

  reg_writeback_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_dest    (alu_dest),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_dest     (ld_dest),
    .ld_data     (ld_data),
    .drain_stall (drain_stall),
    .wr_en       (wr_en),
    .wr_dest     (wr_dest),
    .wr_data     (wr_data),
    .busy        (busy),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [3:0] ad, input logic [31:0] ax,
                       input logic lv, input logic [3:0] lrd, input logic [31:0] lx, input logic st);
    rst         = r;
    alu_valid   = av;
    alu_dest    = ad;
    alu_data    = ax;
    ld_valid    = lv;
    ld_dest     = lrd;
    ld_data     = lx;
    drain_stall = st;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic        av;
    logic [3:0]  ad;
    logic [31:0] ax;
    logic        lv;
    logic [3:0]  lrd;
    logic [31:0] lx;
    logic        st;
    logic        chk_rdy;
    logic        e_alu_rdy;
    logic        e_ld_rdy;
    logic        e_wr_en;
    logic [3:0]  e_dest;
    logic [31:0] e_data;
    logic [15:0] e_busy;
    logic [2:0]  e_count;
  } vec_t;

  localparam int NVEC = 25;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic r, input logic av, input logic [3:0] ad, input logic [31:0] ax,
                              input logic lv, input logic [3:0] lrd, input logic [31:0] lx, input logic st,
                              input logic cr, input logic ear, input logic elr,
                              input logic ew, input logic [3:0] ed, input logic [31:0] ex,
                              input logic [15:0] eb, input logic [2:0] ec);
    vec_t v;
    v = '{rst: r, av: av, ad: ad, ax: ax, lv: lv, lrd: lrd, lx: lx, st: st,
          chk_rdy: cr, e_alu_rdy: ear, e_ld_rdy: elr, e_wr_en: ew, e_dest: ed,
          e_data: ex, e_busy: eb, e_count: ec};
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [3:0]  dest;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        m_wr_en;
  logic [3:0]  m_dest;
  logic [31:0] m_data;
  int unsigned n_writes;

  function automatic logic [15:0] model_busy();
    logic [15:0] b;
    b = '0;
    foreach (mq[i]) b = b | (16'h1 << mq[i].dest);
    return b;
  endfunction

  // Drives inputs at the falling edge, checks ready, advances the model across
  // the rising edge and compares the registered outputs just after it.
  task automatic model_step(input logic r, input logic av, input logic [3:0] ad, input logic [31:0] ax,
                            input logic lv, input logic [3:0] lrd, input logic [31:0] lx, input logic st);
    bit   has_room;
    bit   do_pop;
    ent_t head;
    drive(r, av, ad, ax, lv, lrd, lx, st);
    #1;
    has_room = (mq.size() < DEPTH);
    check("ld_ready", 32'(ld_ready), 32'(has_room));
    check("alu_ready", 32'(alu_ready), 32'(has_room && !lv));
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_wr_en = 1'b0;
      m_dest  = '0;
      m_data  = '0;
    end else begin
      do_pop  = (mq.size() > 0) && !st;
      m_wr_en = do_pop;
      if (do_pop) begin
        head   = mq.pop_front();
        m_dest = head.dest;
        m_data = head.data;
      end
      if (has_room && lv)      mq.push_back('{dest: lrd, data: lx});
      else if (has_room && av) mq.push_back('{dest: ad, data: ax});
    end
    #1;
    check("wr_en", 32'(wr_en), 32'(m_wr_en));
    if (m_wr_en) begin
      check("wr_dest", 32'(wr_dest), 32'(m_dest));
      check("wr_data", wr_data, m_data);
    end
    check("busy", 32'(busy), 32'(model_busy()));
    check("count", 32'(count), 32'(mq.size()));
    if (wr_en === 1'b1) n_writes++;
    @(negedge clk);
  endtask

  initial begin
    drive(1'b1, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0);
    m_wr_en  = 1'b0;
    m_dest   = '0;
    m_data   = '0;
    n_writes = 0;

    //          rst av ad     ax            lv lrd    lx          st  cr ar lr  we ed     ed_data       busy      cnt
    // reset with an ALU request present
    tbl[0]  = mk(1, 1, 4'd3,  32'h33,       0, 4'd0,  32'h0,      0,  0, 0, 0,  0, 4'd0,  32'h0,        16'h0000, 3'd0);
    tbl[1]  = mk(1, 1, 4'd3,  32'h33,       0, 4'd0,  32'h0,      0,  1, 1, 1,  0, 4'd0,  32'h0,        16'h0000, 3'd0);
    tbl[2]  = mk(0, 0, 4'd0,  32'h0,        0, 4'd0,  32'h0,      0,  1, 1, 1,  0, 4'd0,  32'h0,        16'h0000, 3'd0);
    tbl[3]  = mk(0, 0, 4'd0,  32'h0,        0, 4'd0,  32'h0,      0,  1, 1, 1,  0, 4'd0,  32'h0,        16'h0000, 3'd0);
    // single ALU write, 2-edge latency
    tbl[4]  = mk(0, 1, 4'd5,  32'hDEADBEEF, 0, 4'd0,  32'h0,      0,  1, 1, 1,  0, 4'd0,  32'h0,        16'h0020, 3'd1);
    tbl[5]  = mk(0, 0, 4'd0,  32'h0,        0, 4'd0,  32'h0,      0,  1, 1, 1,  1, 4'd5,  32'hDEADBEEF, 16'h0000, 3'd0);
    tbl[6]  = mk(0, 0, 4'd0,  32'h0,        0, 4'd0,  32'h0,      0,  1, 1, 1,  0, 4'd5,  32'hDEADBEEF, 16'h0000, 3'd0);
    // load/ALU collision: load wins, ALU follows
    tbl[7]  = mk(0, 1, 4'd7,  32'h22,       1, 4'd2,  32'h11,     0,  1, 0, 1,  0, 4'd5,  32'hDEADBEEF, 16'h0004, 3'd1);
    tbl[8]  = mk(0, 1, 4'd7,  32'h22,       0, 4'd0,  32'h0,      0,  1, 1, 1,  1, 4'd2,  32'h11,       16'h0080, 3'd1);
    tbl[9]  = mk(0, 0, 4'd0,  32'h0,        0, 4'd0,  32'h0,      0,  1, 1, 1,  1, 4'd7,  32'h22,       16'h0000, 3'd0);
    tbl[10] = mk(0, 0, 4'd0,  32'h0,        0, 4'd0,  32'h0,      0,  1, 1, 1,  0, 4'd7,  32'h22,       16'h0000, 3'd0);
    // fill under stall, then drain
    tbl[11] = mk(0, 1, 4'd1,  32'h101,      0, 4'd0,  32'h0,      1,  1, 1, 1,  0, 4'd7,  32'h22,       16'h0002, 3'd1);
    tbl[12] = mk(0, 1, 4'd2,  32'h102,      0, 4'd0,  32'h0,      1,  1, 1, 1,  0, 4'd7,  32'h22,       16'h0006, 3'd2);
    tbl[13] = mk(0, 1, 4'd3,  32'h103,      0, 4'd0,  32'h0,      1,  1, 1, 1,  0, 4'd7,  32'h22,       16'h000E, 3'd3);
    tbl[14] = mk(0, 1, 4'd4,  32'h104,      0, 4'd0,  32'h0,      1,  1, 1, 1,  0, 4'd7,  32'h22,       16'h001E, 3'd4);
    tbl[15] = mk(0, 1, 4'd5,  32'h105,      1, 4'd6,  32'h66,     1,  1, 0, 0,  0, 4'd7,  32'h22,       16'h001E, 3'd4);
    tbl[16] = mk(0, 0, 4'd0,  32'h0,        1, 4'd6,  32'h66,     0,  1, 0, 0,  1, 4'd1,  32'h101,      16'h001C, 3'd3);
    tbl[17] = mk(0, 0, 4'd0,  32'h0,        0, 4'd0,  32'h0,      0,  1, 1, 1,  1, 4'd2,  32'h102,      16'h0018, 3'd2);
    tbl[18] = mk(0, 0, 4'd0,  32'h0,        0, 4'd0,  32'h0,      0,  1, 1, 1,  1, 4'd3,  32'h103,      16'h0010, 3'd1);
    tbl[19] = mk(0, 0, 4'd0,  32'h0,        0, 4'd0,  32'h0,      0,  1, 1, 1,  1, 4'd4,  32'h104,      16'h0000, 3'd0);
    tbl[20] = mk(0, 0, 4'd0,  32'h0,        0, 4'd0,  32'h0,      0,  1, 1, 1,  0, 4'd4,  32'h104,      16'h0000, 3'd0);
    // back-to-back writes to the same register
    tbl[21] = mk(0, 1, 4'd9,  32'hA,        0, 4'd0,  32'h0,      0,  1, 1, 1,  0, 4'd4,  32'h104,      16'h0200, 3'd1);
    tbl[22] = mk(0, 1, 4'd9,  32'hB,        0, 4'd0,  32'h0,      0,  1, 1, 1,  1, 4'd9,  32'hA,        16'h0200, 3'd1);
    tbl[23] = mk(0, 0, 4'd0,  32'h0,        0, 4'd0,  32'h0,      0,  1, 1, 1,  1, 4'd9,  32'hB,        16'h0000, 3'd0);
    tbl[24] = mk(0, 0, 4'd0,  32'h0,        0, 4'd0,  32'h0,      0,  1, 1, 1,  0, 4'd9,  32'hB,        16'h0000, 3'd0);

    @(negedge clk);
    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].rst, tbl[i].av, tbl[i].ad, tbl[i].ax, tbl[i].lv, tbl[i].lrd, tbl[i].lx, tbl[i].st);
      #1;
      if (tbl[i].chk_rdy) begin
        check($sformatf("vec%0d alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_alu_rdy));
        check($sformatf("vec%0d ld_ready", i), 32'(ld_ready), 32'(tbl[i].e_ld_rdy));
      end
      @(posedge clk);
      #1;
      check($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(tbl[i].e_wr_en));
      check($sformatf("vec%0d wr_dest", i), 32'(wr_dest), 32'(tbl[i].e_dest));
      check($sformatf("vec%0d wr_data", i), wr_data, tbl[i].e_data);
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].e_count));
      @(negedge clk);
    end

    // alternating load/ALU traffic, no stall, across pointer wrap
    model_step(1'b1, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0);
    n_writes = 0;
    for (int i = 0; i < 22; i++) begin
      logic is_ld;
      logic act;
      is_ld = (i % 2 == 0);
      act   = (i < 20);
      model_step(1'b0, act && !is_ld, 4'(i), 32'hA000_0000 + 32'(i),
                 act && is_ld, 4'(15 - i % 16), 32'hB000_0000 + 32'(i), 1'b0);
      n_checks++;
      if (count > 2) begin
        n_fail++;
        $display("FAIL throughput count: got %0d expected <= 2", count);
      end
      if (i >= 1 && i <= 20) check("throughput wr_en", 32'(wr_en), 32'h1);
    end
    check("throughput writes", n_writes, 32'd20);

    // random traffic with stalls and occasional reset
    for (int i = 0; i < 400; i++) begin
      model_step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 1) == 1, 4'($urandom), $urandom,
                 $urandom_range(0, 2) == 0, 4'($urandom), $urandom,
                 $urandom_range(0, 9) < 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_writeback_ctrl.md
Name: reg_writeback_ctrl

Overview:
Write-side sequencer for the 16 x 32-bit register bank.
- Accepts destination-register write requests from two producers: the ALU result path and the memory load (LDR) path, each over a valid/ready handshake.
- Arbitrates between the two and buffers accepted requests in a small FIFO.
- Drains one write per cycle as a registered, one-hot-qualified write (wr_en, wr_dest, wr_data) that feeds the bank's destination decoder and the LDR data input.
- Publishes a per-register pending-write (busy) vector for hazard checking by issue logic.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
alu_valid  in  1  ALU write request present.
alu_ready  out  1  ALU request accepted this cycle when high together with alu_valid.
alu_dest  in  4  ALU destination register index.
alu_data  in  32  ALU result.
ld_valid  in  1  load write request present.
ld_ready  out  1  load request accepted this cycle when high together with ld_valid.
ld_dest  in  4  load destination register index.
ld_data  in  32  loaded word.
drain_stall  in  1  when high, no FIFO entry is issued to the bank this cycle.
wr_en  out  1  registered; bank write strobe; the decoder output is gated by it.
wr_dest  out  4  registered; bank destination select.
wr_data  out  32  registered; bank write data (drives LDR_mux input).
busy  out  16  busy[i] = 1 while any FIFO entry targets register i.
count  out  PTR_W+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=1 at clk edge): FIFO flushed; pointers and count = 0; wr_en = 0; wr_dest = 0; wr_data = 0; busy = 0. A handshake that completes in the same cycle as rst is discarded.
- Reset mid-operation: all pending entries are lost without being written; the next write issues no earlier than 2 cycles after rst falls.
- Acceptance:
  - At most one enqueue per cycle.
  - Load has fixed priority over ALU.
  - ld_ready = !full.
  - alu_ready = !full && !ld_valid.
  - Ready signals are combinational from registered state and ld_valid only. They never depend on alu_valid.
- Full: count == DEPTH. Both ready signals are low, even if a dequeue occurs in the same cycle. There is no full-bypass.
- Empty: count == 0. No dequeue occurs. There is no input-to-output bypass.
- Issue (dequeue):
  - When count > 0 and drain_stall = 0, the head entry is popped.
  - At the next edge the popped entry appears as wr_en = 1 with wr_dest and wr_data from that entry, held for exactly 1 cycle.
  - Otherwise wr_en = 0, and wr_dest/wr_data hold their previous values.
- Latency: a request accepted at edge N, into an empty FIFO with no stall, produces wr_en = 1 in the cycle after edge N+1. Minimum accept-to-write latency is 2 edges.
- Simultaneous enqueue and dequeue (count unchanged): legal whenever not full.
- Pointer wrap: pointers wrap modulo DEPTH. count is tracked separately so that full and empty are unambiguous.
- Ordering: strict FIFO. Two writes to the same register are issued in acceptance order, so the last write wins in the bank.
- busy:
  - Combinational OR over valid FIFO entries of onehot(dest).
  - The bit clears in the cycle the last entry for that register is popped, which is the same cycle wr_en for it becomes registered.
  - Issue logic must therefore treat a register as not yet written until one cycle after busy clears.
- drain_stall held for many cycles: the FIFO fills to DEPTH, the ready signals drop, and no data is lost or reordered.

Decomposition:
- Shared package (reg_bank_pkg): REG_IDX_W = 4, NUM_REGS = 16, DATA_W = 32, and the onehot16 function reused by the bank's destination decoder.
- One sub-module, wb_fifo: a parameterised DEPTH x (4+32) synchronous FIFO with push, pop, full, empty, count, and per-entry valid/dest taps for busy generation.
- The arbiter, issue register and busy OR-reduction live in the top module.

Test Plan:
1. Reset: apply rst for 2 cycles while driving alu_valid=1, alu_dest=3 → wr_en=0, busy=0, count=0, alu_ready=1 after release; no write to r3 issues from the reset-cycle request.
2. Single ALU write: alu_valid=1, alu_dest=5, alu_data=32'hDEADBEEF for 1 cycle → busy[5]=1 for 1 cycle; wr_en=1, wr_dest=5, wr_data=32'hDEADBEEF exactly 2 edges after acceptance; busy returns to 0.
3. Collision: ld (dest=2, data=32'h11) and alu (dest=7, data=32'h22) valid in the same cycle → ld_ready=1, alu_ready=0; r2 is written first, then r7 once the ALU is accepted next cycle; writes are in that order.
4. Full/stall: drain_stall=1, push 4 ALU writes to r1..r4 → count=4, both ready signals 0, busy=16'h001E; release stall → 4 consecutive wr_en pulses, dests 1,2,3,4 with data intact.
5. Same-register ordering: write r9=32'hA then r9=32'hB back-to-back → busy[9] stays 1 until the second pop; wr_data sequence is A then B.
6. Wrap/throughput: continuous alternating ld and alu traffic for 20 cycles with no stall → one write per cycle sustained, count ≤ 2, all 20 writes emitted in acceptance order across pointer wrap.
